// File: rtl/matmul_pkg.sv
// Shared types and helpers for the NxN matrix multiplier: FSM encoding, result width,
// and row-major MSB-first element slicing.
package matmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  function automatic int matmul_ow(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

  // Element idx of a row-major packed matrix sits at this LSB; element 0 lives in the MSBs.
  function automatic int elem_lsb(input int idx, input int n, input int w);
    return (n * n - 1 - idx) * w;
  endfunction

endpackage

// File: rtl/matrix_mult_nxn_if.sv
// Operand/result handshake bundle for matrix_mult_nxn: a/b in with valid/ready,
// res out with valid/ready. Master drives operands and out_ready; slave is the multiplier.
interface matrix_mult_nxn_if #(
  parameter int N  = 2,
  parameter int DW = 8
);
  localparam int OW = matmul_pkg::matmul_ow(DW, N);

  logic              in_valid;
  logic              in_ready;
  logic [N*N*DW-1:0] a;
  logic [N*N*DW-1:0] b;
  logic              out_valid;
  logic              out_ready;
  logic [N*N*OW-1:0] res;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, res
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, res
  );

endinterface

// File: rtl/matmul_mac.sv
// Shared multiply-accumulate: registered DW x DW product feeding an OW accumulator.
// MATMUL_SIGNED_EN selects two's complement operands; otherwise unsigned.
module matmul_mac #(
  parameter int DW = 8,
  parameter int OW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          last,
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] y,
  output logic [OW-1:0] sum,
  output logic          wr
);

  logic [2*DW-1:0] prod;
  logic [OW-1:0]   prod_ext;
  logic [OW-1:0]   prod_q;
  logic [OW-1:0]   acc_q;
  logic            vld_q;
  logic            last_q;

`ifdef MATMUL_SIGNED_EN
  assign prod     = $signed({{DW{x[DW-1]}}, x}) * $signed({{DW{y[DW-1]}}, y});
  assign prod_ext = {{(OW-2*DW){prod[2*DW-1]}}, prod};
`else
  assign prod     = {{DW{1'b0}}, x} * {{DW{1'b0}}, y};
  assign prod_ext = {{(OW-2*DW){1'b0}}, prod};
`endif

  // Product is registered to keep the multiplier off the accumulate path; the
  // accumulator then lags issue by one cycle.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      prod_q <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      acc_q  <= '0;
    end else begin
      prod_q <= prod_ext;
      vld_q  <= en;
      last_q <= en & last;
      if (vld_q) acc_q <= last_q ? '0 : acc_q + prod_q;
    end
  end

  assign sum = acc_q + prod_q;
  assign wr  = vld_q & last_q;

endmodule

// File: rtl/matrix_mult_nxn.sv
// Sequential NxN integer matrix multiplier, C = A x B, one shared MAC walking i/j/k.
// Signedness follows MATMUL_SIGNED_EN (see matmul_mac).
module matrix_mult_nxn
  import matmul_pkg::*;
#(
  parameter int N  = 2,
  parameter int DW = 8
) (
  input logic            clk,
  input logic            rst,
  matrix_mult_nxn_if.slave bus
);

  localparam int OW = matmul_ow(DW, N);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  state_t            state;
  logic [N*N*DW-1:0] a_q;
  logic [N*N*DW-1:0] b_q;
  logic [IW-1:0]     i_q, j_q, k_q;
  logic [IW-1:0]     wi_q, wj_q;
  logic              issue_done;

  logic [DW-1:0]     a_el [N][N];
  logic [DW-1:0]     b_el [N][N];
  logic [OW-1:0]     c_q  [N][N];
  logic [N*N*OW-1:0] res_flat;

  logic              accept;
  logic              mac_en;
  logic              mac_last;
  logic              mac_wr;
  logic [OW-1:0]     mac_sum;

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      assign a_el[r][c] = a_q[elem_lsb(r*N+c, N, DW) +: DW];
      assign b_el[r][c] = b_q[elem_lsb(r*N+c, N, DW) +: DW];
      assign res_flat[elem_lsb(r*N+c, N, OW) +: OW] = c_q[r][c];
    end
  end

  assign bus.res  = res_flat;
  assign accept   = (state == ST_IDLE) && bus.in_valid;
  assign mac_en   = (state == ST_COMPUTE) && !issue_done;
  assign mac_last = (k_q == IDX_LAST);

  matmul_mac #(.DW(DW), .OW(OW)) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (mac_en),
    .last (mac_last),
    .x    (a_el[i_q][k_q]),
    .y    (b_el[k_q][j_q]),
    .sum  (mac_sum),
    .wr   (mac_wr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      i_q           <= '0;
      j_q           <= '0;
      k_q           <= '0;
      wi_q          <= '0;
      wj_q          <= '0;
      issue_done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_q          <= bus.a;
            b_q          <= bus.b;
            i_q          <= '0;
            j_q          <= '0;
            k_q          <= '0;
            issue_done   <= 1'b0;
            bus.in_ready <= 1'b0;
            state        <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          // One drain cycle after the last issue lets the final C element land.
          if (issue_done) begin
            bus.out_valid <= 1'b1;
            state         <= ST_DONE;
          end else begin
            wi_q <= i_q;
            wj_q <= j_q;
            if (k_q == IDX_LAST) begin
              k_q <= '0;
              if (j_q == IDX_LAST) begin
                j_q <= '0;
                if (i_q == IDX_LAST) begin
                  i_q        <= '0;
                  issue_done <= 1'b1;
                end else begin
                  i_q <= i_q + IDX_ONE;
                end
              end else begin
                j_q <= j_q + IDX_ONE;
              end
            end else begin
              k_q <= k_q + IDX_ONE;
            end
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          c_q[r][c] <= '0;
    end else if (mac_wr) begin
      c_q[wi_q][wj_q] <= mac_sum;
    end
  end

endmodule

// File: tb/tb_matrix_mult_nxn.sv
// Self-checking bench for matrix_mult_nxn: directed cases plus random operands against
// a plain-arithmetic matrix product model, on an N=2/DW=8 and an N=3/DW=4 instance.
module tb_matrix_mult_nxn;
  import matmul_pkg::*;

  localparam int N2  = 2;
  localparam int DW2 = 8;
  localparam int OW2 = matmul_ow(DW2, N2);
  localparam int N3  = 3;
  localparam int DW3 = 4;
  localparam int OW3 = matmul_ow(DW3, N3);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_mult_nxn_if #(.N(N2), .DW(DW2)) bus2 ();
  matrix_mult_nxn_if #(.N(N3), .DW(DW3)) bus3 ();

  matrix_mult_nxn #(.N(N2), .DW(DW2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  matrix_mult_nxn #(.N(N3), .DW(DW3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int n_pass  = 0;
  int n_total = 0;
  int overlap = 0;

  always @(negedge clk) begin
    if ((bus2.in_ready && bus2.out_valid) || (bus3.in_ready && bus3.out_valid)) overlap++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int sval(input int v, input int dw);
`ifdef MATMUL_SIGNED_EN
    return (v >= (1 << (dw - 1))) ? v - (1 << dw) : v;
`else
    return v;
`endif
  endfunction

  // C[i][j] = sum_k A[i][k]*B[k][j], reduced to ow bits
  function automatic logic [63:0] ref_elem(input int am[9], input int bm[9], input int n,
                                           input int dw, input int ow, input int i, input int j);
    longint s = 0;
    for (int k = 0; k < n; k++)
      s += longint'(sval(am[i*n+k], dw)) * longint'(sval(bm[k*n+j], dw));
    return 64'(s) & ((64'd1 << ow) - 64'd1);
  endfunction

  function automatic logic [127:0] pack(input int m[9], input int n, input int w);
    logic [127:0] v = '0;
    for (int e = 0; e < n*n; e++) begin
      int t = m[e];
      for (int bt = 0; bt < w; bt++) v[(n*n-1-e)*w + bt] = t[bt];
    end
    return v;
  endfunction

  function automatic logic [63:0] get_el(input logic [127:0] r, input int n, input int w, input int e);
    logic [63:0] v = '0;
    for (int bt = 0; bt < w; bt++) v[bt] = r[(n*n-1-e)*w + bt];
    return v;
  endfunction

  function automatic logic [127:0] res2();
    logic [127:0] r = '0;
    r[N2*N2*OW2-1:0] = bus2.res;
    return r;
  endfunction

  function automatic logic [127:0] res3();
    logic [127:0] r = '0;
    r[N3*N3*OW3-1:0] = bus3.res;
    return r;
  endfunction

  task automatic start2(input int am[9], input int bm[9]);
    logic [127:0] pa, pb;
    int t = 0;
    pa = pack(am, N2, DW2);
    pb = pack(bm, N2, DW2);
    @(negedge clk);
    bus2.a = pa[N2*N2*DW2-1:0];
    bus2.b = pb[N2*N2*DW2-1:0];
    bus2.in_valid = 1'b1;
    while (!bus2.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("accept_bound", 64'(t < 100), 64'd1);
    @(posedge clk);
    #1 bus2.in_valid = 1'b0;
  endtask

  task automatic wait_valid2(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!bus2.out_valid && lat < 200);
  endtask

  task automatic check_res2(input string tag, input int am[9], input int bm[9], input logic [127:0] r);
    for (int e = 0; e < N2*N2; e++)
      check($sformatf("%s[%0d]", tag, e), get_el(r, N2, OW2, e),
            ref_elem(am, bm, N2, DW2, OW2, e / N2, e % N2));
  endtask

  task automatic drain2(input string tag);
    @(negedge clk);
    bus2.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_out_valid_drop"}, 64'(bus2.out_valid), 64'd0);
    check({tag, "_in_ready_back"}, 64'(bus2.in_ready), 64'd1);
    bus2.out_ready = 1'b0;
  endtask

  initial begin
    int am[9], bm[9], am2[9], bm2[9];
    int lat, stable, cnt, got, cyc;
    logic acc2_pending;
    logic [127:0] r0;
    logic [127:0] res_q[$];
    int exp1[4];

    rst = 1'b1;
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b0; bus2.a = '0; bus2.b = '0;
    bus3.in_valid = 1'b0; bus3.out_ready = 1'b0; bus3.a = '0; bus3.b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_in_ready", 64'(bus2.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus2.out_valid), 64'd0);
    check("rst_res", res2(), 64'd0);
    check("rst3_in_ready", 64'(bus3.in_ready), 64'd1);

    // 1: basic product and latency
    am = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
    bm = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
    exp1 = '{19, 22, 43, 50};
    start2(am, bm);
    wait_valid2(lat);
    check("t1_latency", 64'(lat), 64'd9);
    for (int e = 0; e < 4; e++)
      check($sformatf("t1_res[%0d]", e), get_el(res2(), N2, OW2, e), 64'(exp1[e]));
    drain2("t1");

    // 2: full-scale operands
    am = '{255, 255, 255, 255, 0, 0, 0, 0, 0};
    start2(am, am);
    wait_valid2(lat);
    for (int e = 0; e < 4; e++)
`ifdef MATMUL_SIGNED_EN
      check($sformatf("t2_res[%0d]", e), get_el(res2(), N2, OW2, e), 64'd2);
`else
      check($sformatf("t2_res[%0d]", e), get_el(res2(), N2, OW2, e), 64'd130050);
`endif
    drain2("t2");

    // 3: backpressure
    for (int e = 0; e < 4; e++) begin
      am[e] = int'($urandom_range(255));
      bm[e] = int'($urandom_range(255));
    end
    start2(am, bm);
    wait_valid2(lat);
    r0 = res2();
    stable = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (res2() === r0 && bus2.out_valid && !bus2.in_ready) stable++;
    end
    check("t3_stable_cycles", 64'(stable), 64'd20);
    check_res2("t3_res", am, bm, res2());
    drain2("t3");

    // 4: reset mid-compute, then a fresh op
    am = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
    bm = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
    start2(am, bm);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("t4_out_valid", 64'(bus2.out_valid), 64'd0);
    check("t4_res_cleared", res2(), 64'd0);
    check("t4_in_ready", 64'(bus2.in_ready), 64'd1);
    am = '{2, 0, 0, 2, 0, 0, 0, 0, 0};
    bm = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
    exp1 = '{2, 4, 6, 8};
    start2(am, bm);
    wait_valid2(lat);
    check("t4_latency", 64'(lat), 64'd9);
    for (int e = 0; e < 4; e++)
      check($sformatf("t4_res[%0d]", e), get_el(res2(), N2, OW2, e), 64'(exp1[e]));
    drain2("t4");

    // rst and in_valid together: nothing accepted
    @(negedge clk);
    rst = 1'b1;
    bus2.in_valid = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bus2.in_valid = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus2.out_valid || !bus2.in_ready) cnt++;
    end
    check("rst_beats_valid", 64'(cnt), 64'd0);

    // 5: back-to-back with in_valid held high; operands change right after accept
    am  = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
    bm  = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
    am2 = '{1, 0, 0, 1, 0, 0, 0, 0, 0};
    bm2 = '{9, 8, 7, 6, 0, 0, 0, 0, 0};
    r0 = pack(am, N2, DW2);
    @(negedge clk);
    bus2.a = r0[N2*N2*DW2-1:0];
    r0 = pack(bm, N2, DW2);
    bus2.b = r0[N2*N2*DW2-1:0];
    bus2.in_valid = 1'b1;
    bus2.out_ready = 1'b1;
    @(posedge clk);
    #1;
    r0 = pack(am2, N2, DW2);
    bus2.a = r0[N2*N2*DW2-1:0];
    r0 = pack(bm2, N2, DW2);
    bus2.b = r0[N2*N2*DW2-1:0];
    got = 0; cyc = 0; acc2_pending = 1'b0;
    while (got < 2 && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
      if (acc2_pending) begin
        bus2.in_valid = 1'b0;
        acc2_pending = 1'b0;
      end
      if (bus2.out_valid) begin
        res_q.push_back(res2());
        got++;
      end
      if (bus2.in_ready && bus2.in_valid && got == 1) begin
        check("t5_accept_in_idle", 64'(bus2.out_valid), 64'd0);
        acc2_pending = 1'b1;
      end
    end
    bus2.in_valid = 1'b0;
    check("t5_result_count", 64'(got), 64'd2);
    if (res_q.size() == 2) begin
      check_res2("t5_first", am, bm, res_q[0]);
      check_res2("t5_second", am2, bm2, res_q[1]);
    end
    @(posedge clk);
    #1 bus2.out_ready = 1'b0;
    check("t5_in_ready_after", 64'(bus2.in_ready), 64'd1);

    // random N=2 ops with random backpressure
    for (int op = 0; op < 6; op++) begin
      for (int e = 0; e < 4; e++) begin
        am[e] = int'($urandom_range(255));
        bm[e] = int'($urandom_range(255));
      end
      start2(am, bm);
      wait_valid2(lat);
      check($sformatf("rnd%0d_latency", op), 64'(lat), 64'd9);
      repeat ($urandom_range(3)) @(posedge clk);
      #1 check_res2($sformatf("rnd%0d_res", op), am, bm, res2());
      drain2($sformatf("rnd%0d", op));
    end

    // 6: N=3, DW=4 -- identity x {1..9}, then a random pair
    for (int op = 0; op < 2; op++) begin
      logic [127:0] pa, pb;
      int t = 0;
      for (int e = 0; e < 9; e++) begin
        if (op == 0) begin
          am[e] = (e % 4 == 0) ? 1 : 0;
          bm[e] = e + 1;
        end else begin
          am[e] = int'($urandom_range(15));
          bm[e] = int'($urandom_range(15));
        end
      end
      pa = pack(am, N3, DW3);
      pb = pack(bm, N3, DW3);
      @(negedge clk);
      bus3.a = pa[N3*N3*DW3-1:0];
      bus3.b = pb[N3*N3*DW3-1:0];
      bus3.in_valid = 1'b1;
      while (!bus3.in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("n3_accept_bound", 64'(t < 100), 64'd1);
      @(posedge clk);
      #1 bus3.in_valid = 1'b0;
      lat = 0;
      do begin
        @(posedge clk);
        #1 lat++;
      end while (!bus3.out_valid && lat < 200);
      check($sformatf("n3_op%0d_latency", op), 64'(lat), 64'd28);
      for (int e = 0; e < 9; e++)
        check($sformatf("n3_op%0d_res[%0d]", op, e), get_el(res3(), N3, OW3, e),
              ref_elem(am, bm, N3, DW3, OW3, e / N3, e % N3));
      @(negedge clk);
      bus3.out_ready = 1'b1;
      @(posedge clk);
      #1 bus3.out_ready = 1'b0;
      check($sformatf("n3_op%0d_in_ready", op), 64'(bus3.in_ready), 64'd1);
    end

    check("ready_valid_overlap", 64'(overlap), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
